ahb_bus_arbiter: RTL and testbench

Round-robin AHB-lite bus arbiter that shares the single ahb_lite_top bus (RAM / register / UART slaves) between NUM_MASTERS requesters (CPU fetch, CPU data, UART loader).
- Samples the per-master hbusreq, issues a registered one-hot grant and drives the address-phase and data-phase master indices.
- The top-level address/write-data muxes use those indices.
- A hold counter bounds bus tenure so no master can starve the others.

---
 rtl/ahb_pkg.sv | 18 +
 rtl/ahb_bus_arbiter_rr_pick.sv | 37 +++
 rtl/ahb_bus_arbiter.sv | 118 +++++++++++
 tb/tb_ahb_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared types and constants for the AHB-lite bus arbiter and its helpers.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int MAX_MASTERS = 8;

  // AHB-lite bus widths shared with the rest of the ahb_lite_top slice
  localparam int HADDR_W  = 32;
  localparam int HDATA_W  = 32;
  localparam int HTRANS_W = 2;
  localparam int HSIZE_W  = 3;

endpackage

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping.
module rr_pick #(
  parameter  int NUM_MASTERS = 3,
  localparam int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          last_owner,
  output logic [MW-1:0]          winner,
  output logic                   valid
);

  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  logic [MW:0]              start;
  logic [MW-1:0]            offset;
  logic [MW+1:0]            sum;

  // Rotating a doubled copy puts the search start at bit 0, so the lowest
  // set bit of req_rot is the round-robin winner's distance from start.
  always_comb begin
    start   = {1'b0, last_owner} + (MW+1)'(1);
    req_dbl = {req, req};
    req_rot = NUM_MASTERS'(req_dbl >> start);
    valid   = 1'b0;
    offset  = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        valid  = 1'b1;
        offset = MW'(k);
      end
    end
    sum    = (MW+2)'(start) + (MW+2)'(offset);
    winner = (sum >= (MW+2)'(NUM_MASTERS)) ? MW'(sum - (MW+2)'(NUM_MASTERS))
                                           : MW'(sum);
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-lite arbiter with bounded tenure and a data-phase owner index.
//   state | meaning
//   IDLE  | no grant
//   OWN   | one master granted
//   DRAIN | grant released, last data phase pending
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter  int NUM_MASTERS = 3,
  parameter  int MAX_HOLD    = 16,
  localparam int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] hbusreq_i,
  input  logic                   haddr_ctrl_i,
  input  logic                   hready_i,
  output logic [NUM_MASTERS-1:0] hgrant_o,
  output logic [MW-1:0]          hmaster_o,
  output logic [MW-1:0]          hmaster_data_o,
  output logic                   bus_busy_o
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t             state, state_nxt;
  logic [HW-1:0]          hold_cnt, hold_nxt;
  logic [MW-1:0]          last_owner, last_nxt;
  logic [MW-1:0]          hmaster_nxt, hmaster_data_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [MW-1:0]          pick_winner;
  logic                   pick_valid;
  logic                   owner_req, others_req, hold_max;
  logic                   take_grant, drop_grant;

  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_rr_pick (
    .req        (hbusreq_i),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign owner_req  = hbusreq_i[hmaster_o];
  assign others_req = |(hbusreq_i & ~hgrant_o);
  assign hold_max   = (hold_cnt == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      last_owner     <= MW'(NUM_MASTERS - 1);
      hgrant_o       <= '0;
      hmaster_o      <= '0;
      hmaster_data_o <= '0;
      bus_busy_o     <= 1'b0;
    end else begin
      state          <= state_nxt;
      hold_cnt       <= hold_nxt;
      last_owner     <= last_nxt;
      hgrant_o       <= grant_nxt;
      hmaster_o      <= hmaster_nxt;
      hmaster_data_o <= hmaster_data_nxt;
      bus_busy_o     <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    drop_grant = 1'b0;
    if (hready_i) begin
      case (state)
        IDLE, DRAIN: begin
          if (pick_valid) begin
            state_nxt  = OWN;
            take_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        OWN: begin
          // With the owner's request gone, any valid pick is another master.
          if (!owner_req) begin
            if (pick_valid) begin
              take_grant = 1'b1;
            end else begin
              drop_grant = 1'b1;
              state_nxt  = haddr_ctrl_i ? DRAIN : IDLE;
            end
          end else if (hold_max && others_req && !haddr_ctrl_i) begin
            take_grant = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    grant_nxt        = hgrant_o;
    hmaster_nxt      = hmaster_o;
    last_nxt         = last_owner;
    hold_nxt         = hold_cnt;
    hmaster_data_nxt = (hready_i && haddr_ctrl_i) ? hmaster_o : hmaster_data_o;
    if (take_grant) begin
      grant_nxt   = NUM_MASTERS'(1) << pick_winner;
      hmaster_nxt = pick_winner;
      last_nxt    = pick_winner;
      hold_nxt    = '0;
    end else if (drop_grant) begin
      grant_nxt = '0;
      hold_nxt  = '0;
    end else if (hready_i && (state == OWN) && !hold_max) begin
      hold_nxt = hold_cnt + HW'(1);
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios plus randomized run vs a behavioural model.
module tb_ahb_bus_arbiter;

  localparam int N    = 3;
  localparam int MAXH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         addr_ctrl = 1'b0;
  logic         ready = 1'b1;
  logic [N-1:0] hgrant_o;
  logic [1:0]   hmaster_o, hmaster_data_o;
  logic         bus_busy_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model: owner is -1 when nobody holds the bus.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_hold  = 0;
  int m_addr  = 0;
  int m_data  = 0;
  bit m_drain = 1'b0;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MAXH)) dut (
    .clk            (clk),
    .rst            (rst),
    .hbusreq_i      (req),
    .haddr_ctrl_i   (addr_ctrl),
    .hready_i       (ready),
    .hgrant_o       (hgrant_o),
    .hmaster_o      (hmaster_o),
    .hmaster_data_o (hmaster_data_o),
    .bus_busy_o     (bus_busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert ($onehot0(hgrant_o)) else $error("FAIL onehot0 grant=%b", hgrant_o);
  end

  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++) begin
      if (r[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_owner = w;
    m_addr  = w;
    m_last  = w;
    m_hold  = 0;
    m_drain = 1'b0;
  endtask

  task automatic model_edge();
    int w;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_hold = 0;
      m_addr = 0; m_data = 0; m_drain = 1'b0;
      return;
    end
    if (!ready) return;
    if (addr_ctrl) m_data = m_addr;
    w = rr_winner(req, m_last);
    if (m_owner < 0 || !req[m_owner]) begin
      if (w >= 0) model_grant(w);
      else begin
        m_drain = (m_owner >= 0) && addr_ctrl;
        m_owner = -1;
      end
    end else if (m_hold == MAXH - 1 && w != m_owner && !addr_ctrl) begin
      model_grant(w);
    end else if (m_hold < MAXH - 1) begin
      m_hold++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b1; req = '0; addr_ctrl = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0; req = 3'b111; addr_ctrl = 1'b1;
    tick();
    total++; if (hgrant_o !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b want=000", hgrant_o); end
    total++; if (hmaster_o !== 2'd0) begin bad++; $display("FAIL reset_hmaster got=%0d want=0", hmaster_o); end
    total++; if (hmaster_data_o !== 2'd0) begin bad++; $display("FAIL reset_hmaster_data got=%0d want=0", hmaster_data_o); end
    total++; if (bus_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_busy_o); end
    do_reset();
  endtask

  task automatic test_single_request();
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    req = 3'b010;
    tick();
    total++; if (hgrant_o !== 3'b010) begin bad++; $display("FAIL single_grant got=%b want=010", hgrant_o); end
    total++; if (hmaster_o !== 2'd1) begin bad++; $display("FAIL single_hmaster got=%0d want=1", hmaster_o); end
    total++; if (bus_busy_o !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", bus_busy_o); end
    req = 3'b000;
    tick();
    total++; if (bus_busy_o !== 1'b0) begin bad++; $display("FAIL single_release_busy got=%b want=0", bus_busy_o); end
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{0, 1, 2, 0};
    int g;
    int prev_data;
    do_reset();
    req = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      g = exp_order[k];
      total++; if (hgrant_o !== 3'(1 << g)) begin bad++; $display("FAIL rr_grant step=%0d got=%b want=%b", k, hgrant_o, 3'(1 << g)); end
      total++; if (hmaster_o !== 2'(g)) begin bad++; $display("FAIL rr_hmaster step=%0d got=%0d want=%0d", k, hmaster_o, g); end
      prev_data = (k == 0) ? 0 : exp_order[k-1];
      total++; if (hmaster_data_o !== 2'(prev_data)) begin bad++; $display("FAIL rr_data_lag step=%0d got=%0d want=%0d", k, hmaster_data_o, prev_data); end
      addr_ctrl = 1'b1;
      tick();
      total++; if (hmaster_data_o !== 2'(g)) begin bad++; $display("FAIL rr_data step=%0d got=%0d want=%0d", k, hmaster_data_o, g); end
      addr_ctrl = 1'b0;
      req[g] = 1'b0;
      tick();
      req[g] = 1'b1;
    end
    req = '0;
    tick();
  endtask

  task automatic test_preempt(input bit defer);
    int moved_at;
    int want_at;
    do_reset();
    req = 3'b001;
    tick();
    moved_at = -1;
    want_at  = defer ? MAXH + 1 : MAXH;
    for (int t = 1; t <= 40; t++) begin
      if (t == 5) req = 3'b101;
      addr_ctrl = (defer && t == MAXH) ? 1'b1 : 1'b0;
      tick();
      if (hgrant_o !== 3'b001) begin
        moved_at = t;
        break;
      end
    end
    addr_ctrl = 1'b0;
    total++; if (moved_at != want_at) begin bad++; $display("FAIL preempt_time defer=%0d got=%0d want=%0d", defer, moved_at, want_at); end
    total++; if (hgrant_o !== 3'b100) begin bad++; $display("FAIL preempt_grant defer=%0d got=%b want=100", defer, hgrant_o); end
    total++; if (hmaster_o !== 2'd2) begin bad++; $display("FAIL preempt_hmaster defer=%0d got=%0d want=2", defer, hmaster_o); end
    total++; if (hmaster_data_o !== 2'd0) begin bad++; $display("FAIL preempt_data defer=%0d got=%0d want=0", defer, hmaster_data_o); end
    req = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    req = 3'b001;
    tick();
    ready = 1'b0;
    req = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (hgrant_o !== 3'b001) begin bad++; $display("FAIL stall_hold cyc=%0d got=%b want=001", i, hgrant_o); end
    end
    ready = 1'b1;
    tick();
    total++; if (hgrant_o !== 3'b010) begin bad++; $display("FAIL stall_release got=%b want=010", hgrant_o); end
    total++; if (hmaster_o !== 2'd1) begin bad++; $display("FAIL stall_hmaster got=%0d want=1", hmaster_o); end
    req = '0;
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    req = 3'b010;
    tick();
    req = 3'b000;
    addr_ctrl = 1'b1;
    tick();
    total++; if (hgrant_o !== 3'b000) begin bad++; $display("FAIL drain_grant got=%b want=000", hgrant_o); end
    total++; if (bus_busy_o !== 1'b1) begin bad++; $display("FAIL drain_busy got=%b want=1", bus_busy_o); end
    total++; if (hmaster_data_o !== 2'd1) begin bad++; $display("FAIL drain_data got=%0d want=1", hmaster_data_o); end
    addr_ctrl = 1'b0;
    ready = 1'b0;
    tick();
    total++; if (bus_busy_o !== 1'b1) begin bad++; $display("FAIL drain_stall_busy got=%b want=1", bus_busy_o); end
    ready = 1'b1;
    tick();
    total++; if (bus_busy_o !== 1'b0) begin bad++; $display("FAIL drain_done_busy got=%b want=0", bus_busy_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b010;
    addr_ctrl = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    rst = 1'b1;
    tick();
    total++; if (hgrant_o !== 3'b000) begin bad++; $display("FAIL midrst_grant got=%b want=000", hgrant_o); end
    total++; if (hmaster_o !== 2'd0 || hmaster_data_o !== 2'd0) begin bad++; $display("FAIL midrst_index got=%0d/%0d want=0/0", hmaster_o, hmaster_data_o); end
    total++; if (bus_busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus_busy_o); end
    rst = 1'b0;
    ready = 1'b1;
    addr_ctrl = 1'b0;
    req = 3'b011;
    tick();
    total++; if (hgrant_o !== 3'b001) begin bad++; $display("FAIL midrst_first_win got=%b want=001", hgrant_o); end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_grant;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      ready = ($urandom_range(0, 3) != 0);
      addr_ctrl = 1'($urandom_range(0, 1));
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
      end
      tick();
      exp_grant = (m_owner < 0) ? '0 : N'(1 << m_owner);
      total++; if (hgrant_o !== exp_grant) begin bad++; $display("FAIL rand_grant cyc=%0d got=%b want=%b", c, hgrant_o, exp_grant); end
      total++; if (hmaster_o !== 2'(m_addr)) begin bad++; $display("FAIL rand_hmaster cyc=%0d got=%0d want=%0d", c, hmaster_o, m_addr); end
      total++; if (hmaster_data_o !== 2'(m_data)) begin bad++; $display("FAIL rand_data cyc=%0d got=%0d want=%0d", c, hmaster_data_o, m_data); end
      total++; if (bus_busy_o !== ((m_owner >= 0) || m_drain)) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", c, bus_busy_o, (m_owner >= 0) || m_drain); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_preempt(1'b0);
    test_preempt(1'b1);
    test_stall();
    test_drain();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
